// File: rtl/period_detector.sv
`default_nettype none
// ============================================================================
// Module   : period_detector
// Purpose  : Measures waveform period (in samples) between rising crossings of
//            a signed sample stream, with hysteresis and a no-crossing timeout.
// Revision : 1.0 - initial release
// ============================================================================
module period_detector #(
    parameter int width_p        = 12,
    parameter int max_period_p   = 1024,
    parameter int hyst_p         = 0,
    parameter int period_width_p = $clog2(max_period_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        valid_i,
    input  logic signed [width_p-1:0]   data_i,
    output logic                        ready_o,
    output logic [period_width_p-1:0]   period_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        timeout_o
);

    localparam logic signed [width_p:0]        c_hyst_pos  = (width_p + 1)'(hyst_p);
    localparam logic signed [width_p:0]        c_hyst_neg  = -c_hyst_pos;
    localparam logic [period_width_p-1:0]      c_max_count = period_width_p'(max_period_p);
    localparam logic [period_width_p-1:0]      c_one       = period_width_p'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [period_width_p-1:0]   r_count;
    logic [period_width_p-1:0]   w_count_next;
    logic                        r_level_high;
    logic                        w_level_high_next;
    logic [period_width_p-1:0]   r_period;
    logic                        r_valid;
    logic                        r_timeout;
    logic                        w_load;
    logic                        w_timeout_next;
    logic                        w_accept;
    logic                        w_high;
    logic                        w_low;
    logic                        w_rise;
    logic signed [width_p:0]     w_data_ext;

    assign ready_o   = !r_valid | ready_i;
    assign valid_o   = r_valid;
    assign period_o  = r_period;
    assign timeout_o = r_timeout;

    assign w_accept   = valid_i & ready_o;
    assign w_data_ext = {data_i[width_p-1], data_i};
    assign w_high     = (w_data_ext > c_hyst_pos);
    assign w_low      = (w_data_ext < c_hyst_neg);
    // Level is only meaningful outside IDLE; IDLE itself encodes "unknown".
    assign w_rise     = w_high & !r_level_high;

    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_level_high_next = r_level_high;
        w_load            = 1'b0;
        w_timeout_next    = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_low) begin
                        w_state_next      = ST_ARMED;
                        w_level_high_next = 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (w_rise) begin
                        w_state_next      = ST_MEASURE;
                        w_count_next      = c_one;
                        w_level_high_next = 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        w_load            = 1'b1;
                        w_count_next      = c_one;
                        w_level_high_next = 1'b1;
                    end else if (r_count == c_max_count) begin
                        w_timeout_next    = 1'b1;
                        w_count_next      = '0;
                        w_state_next      = ST_IDLE;
                    end else begin
                        w_count_next = r_count + c_one;
                        if (w_low) begin
                            w_level_high_next = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_level_high <= 1'b0;
            r_period     <= '0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_level_high <= w_level_high_next;
            r_timeout    <= w_timeout_next;
            // A freshly loaded result wins over a same-cycle consume.
            if (w_load) begin
                r_period <= r_count;
                r_valid  <= 1'b1;
            end else if (ready_i) begin
                r_valid  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_period_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_period_detector
// Purpose  : Directed self-checking bench for period_detector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_period_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: default parameters
    logic               a_reset = 1'b1;
    logic               a_valid_i = 1'b0;
    logic signed [11:0] a_data = '0;
    logic               a_ready_o;
    logic [10:0]        a_period_o;
    logic               a_valid_o;
    logic               a_ready_i = 1'b1;
    logic               a_timeout_o;

    // Instance B: hysteresis 100, max period 64
    logic               b_reset = 1'b1;
    logic               b_valid_i = 1'b0;
    logic signed [11:0] b_data = '0;
    logic               b_ready_o;
    logic [6:0]         b_period_o;
    logic               b_valid_o;
    logic               b_ready_i = 1'b1;
    logic               b_timeout_o;

    period_detector dut_a (
        .clk_i    (clk),
        .reset_i  (a_reset),
        .valid_i  (a_valid_i),
        .data_i   (a_data),
        .ready_o  (a_ready_o),
        .period_o (a_period_o),
        .valid_o  (a_valid_o),
        .ready_i  (a_ready_i),
        .timeout_o(a_timeout_o)
    );

    period_detector #(
        .width_p     (12),
        .max_period_p(64),
        .hyst_p      (100)
    ) dut_b (
        .clk_i    (clk),
        .reset_i  (b_reset),
        .valid_i  (b_valid_i),
        .data_i   (b_data),
        .ready_o  (b_ready_o),
        .period_o (b_period_o),
        .valid_o  (b_valid_o),
        .ready_i  (b_ready_i),
        .timeout_o(b_timeout_o)
    );

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Square wave: index 0 = 0, first half +2047, second half -2047.
    // Optional +/-50 glitches at the quarter points fall inside the hysteresis band.
    function automatic logic signed [11:0] sq(input int idx, input int per, input bit glitch);
        int p;
        p = idx % per;
        if (glitch && p == per / 4)         return -12'sd50;
        if (glitch && p == (3 * per) / 4)   return 12'sd50;
        if (p == 0)                         return 12'sd0;
        if (p < per / 2)                    return 12'sd2047;
        return -12'sd2047;
    endfunction

    task automatic step_a(input logic signed [11:0] d);
        a_valid_i = 1'b1;
        a_data    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic signed [11:0] d);
        b_valid_i = 1'b1;
        b_data    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        a_reset   = 1'b1;
        a_valid_i = 1'b0;
        @(posedge clk);
        #1;
        a_reset = 1'b0;
        check("a_rst_valid",   a_valid_o,   0);
        check("a_rst_period",  a_period_o,  0);
        check("a_rst_ready",   a_ready_o,   1);
        check("a_rst_timeout", a_timeout_o, 0);
    endtask

    task automatic reset_b();
        b_reset   = 1'b1;
        b_valid_i = 1'b0;
        @(posedge clk);
        #1;
        b_reset = 1'b0;
        check("b_rst_valid",   b_valid_o,   0);
        check("b_rst_period",  b_period_o,  0);
        check("b_rst_ready",   b_ready_o,   1);
        check("b_rst_timeout", b_timeout_o, 0);
    endtask

    // Feed period-100 samples [first..last]; results expected at r0, r0+100, ...
    task automatic run_a(input string name, input int first, input int last, input int r0);
        bit exp_v;
        for (int k = first; k <= last; k++) begin
            step_a(sq(k, 100, 1'b0));
            exp_v = (k >= r0) && (((k - r0) % 100) == 0);
            check({name, "_valid"}, a_valid_o, int'(exp_v));
            if (exp_v) check({name, "_period"}, a_period_o, 100);
            check({name, "_timeout"}, a_timeout_o, 0);
        end
    endtask

    task automatic run_b(input string name, input int first, input int last,
                         input int per, input bit glitch, input int r0);
        bit exp_v;
        for (int k = first; k <= last; k++) begin
            step_b(sq(k, per, glitch));
            exp_v = (k >= r0) && (((k - r0) % per) == 0);
            check({name, "_valid"}, b_valid_o, int'(exp_v));
            if (exp_v) check({name, "_period"}, b_period_o, per);
            check({name, "_timeout"}, b_timeout_o, 0);
        end
    endtask

    initial begin
        #1;
        reset_a();
        reset_b();

        // Clean square from index 0: low at 50 arms, rise at 101, results from 201
        a_ready_i = 1'b1;
        run_a("t1", 0, 420, 201);

        // Start in high phase
        reset_a();
        run_a("t2", 10, 310, 201);

        // Backpressure on first result
        reset_a();
        a_ready_i = 1'b0;
        run_a("t3a", 0, 201, 201);
        for (int i = 0; i < 3; i++) begin
            step_a(sq(202, 100, 1'b0));
            check("t3_hold_valid",  a_valid_o,  1);
            check("t3_hold_period", a_period_o, 100);
            check("t3_hold_ready",  a_ready_o,  0);
        end
        a_ready_i = 1'b1;
        step_a(sq(202, 100, 1'b0));
        a_ready_i = 1'b0;
        check("t3_take_valid", a_valid_o, 0);
        check("t3_take_ready", a_ready_o, 1);
        a_ready_i = 1'b1;
        run_a("t3b", 203, 401, 301);

        // Reset mid-period: next low at 251 arms, rise at 301, first result at 401
        reset_a();
        run_a("t6a", 0, 250, 201);
        reset_a();
        run_a("t6b", 251, 410, 401);

        // Hysteresis: period 40 with in-band glitches; arm at 20, rise at 41
        b_ready_i = 1'b1;
        run_b("t4", 0, 170, 40, 1'b1, 81);

        // Timeout: low, high (crossing), then constant high
        reset_b();
        step_b(-12'sd2047);
        step_b(12'sd2047);
        for (int k = 2; k <= 80; k++) begin
            step_b(12'sd2047);
            check("t5_timeout", b_timeout_o, (k == 65) ? 1 : 0);
            check("t5_valid",   b_valid_o,   0);
        end
        // Back from IDLE: period-20 square arms at 10, rises at 21
        run_b("t5b", 0, 70, 20, 1'b0, 41);

        // Period exactly at max_period: arms at 32, rises at 65, result at 129
        reset_b();
        run_b("t5c", 0, 200, 64, 1'b0, 129);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
